// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: instruction layout, opcodes,
// sequencer states and opcode classification helpers.
package control_unit_pkg;

  localparam int WORD_SIZE = 19;

  localparam int OPC_MSB = 18;
  localparam int OPC_LSB = 14;
  localparam int RD_MSB  = 13;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 5;
  localparam int IMM_MSB = 4;
  localparam int IMM_LSB = 0;

  localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
  localparam int REG_W = RD_MSB - RD_LSB + 1;
  localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

  // Encodings 9..31 are unassigned and decode as illegal.
  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 5'd0,
    OP_HALT = 5'd1,
    OP_JMP  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOT  = 5'd6,
    OP_ADD  = 5'd7,
    OP_SUB  = 5'd8
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT_ST
  } cu_state_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOP, OP_HALT, OP_JMP, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_ADD, OP_SUB: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Control-flow and no-op classes never touch the register file.
  function automatic logic writes_reg(input opcode_t op);
    return !(op inside {OP_NOP, OP_JMP, OP_HALT});
  endfunction

endpackage

// File: rtl/control_bus_if.sv
// Control bus between the sequencer and the datapath (ALU, logic unit, RF).
interface control_bus_if;
  import control_unit_pkg::*;

  opcode_t          OPCODE;
  logic [REG_W-1:0] RD;
  logic [REG_W-1:0] RS1;
  logic [REG_W-1:0] RS2;
  logic [IMM_W-1:0] IMM;
  logic             REG_WE;

  modport CU (output OPCODE, RD, RS1, RS2, IMM, REG_WE);
  modport DP (input  OPCODE, RD, RS1, RS2, IMM, REG_WE);
endinterface

// File: rtl/control_unit_instr_decoder.sv
// Combinational instruction decoder: splits the IR into bus fields and
// classifies the opcode. Illegal opcodes are presented as NOP.
module instr_decoder
  import control_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0] ir,
  output opcode_t              opcode,
  output logic [REG_W-1:0]     rd,
  output logic [REG_W-1:0]     rs1,
  output logic [REG_W-1:0]     rs2,
  output logic [IMM_W-1:0]     imm,
  output logic                 legal,
  output logic                 wr_reg
);

  logic [OPC_W-1:0] opc_raw;

  // Field extraction and opcode classification.
  always_comb begin
    opc_raw = ir[OPC_MSB:OPC_LSB];
    legal   = is_legal(opc_raw);
    opcode  = legal ? opcode_t'(opc_raw) : OP_NOP;
    wr_reg  = legal && writes_reg(opcode);
    rd      = ir[RD_MSB:RD_LSB];
    rs1     = ir[RS1_MSB:RS1_LSB];
    rs2     = ir[RS2_MSB:RS2_LSB];
    imm     = ir[IMM_MSB:IMM_LSB];
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches words over a valid/ready handshake, decodes
// them and drives the control bus through FETCH/DECODE/EXEC/WB.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int          PC_WIDTH     = 8,
  parameter int unsigned RESET_PC     = 0,
  parameter int          EXEC_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  control_bus_if.CU            ctrl_bus_if,
  output logic [PC_WIDTH-1:0]  instr_addr,
  output logic                 instr_req,
  input  logic                 instr_ack,
  input  logic [WORD_SIZE-1:0] instr_data,
  input  logic                 exec_multi,
  input  logic                 exec_done,
  output logic                 halted,
  output logic                 fault
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

  cu_state_t            state;
  cu_state_t            state_nxt;
  logic [PC_WIDTH-1:0]  pc;
  logic [WORD_SIZE-1:0] ir;
  logic [CNT_W-1:0]     exec_cnt;

  opcode_t              dec_opcode;
  logic [REG_W-1:0]     dec_rd;
  logic [REG_W-1:0]     dec_rs1;
  logic [REG_W-1:0]     dec_rs2;
  logic [IMM_W-1:0]     dec_imm;
  logic                 dec_legal;
  logic                 dec_wr;

  logic                 exec_go_wb;
  logic                 exec_timeout;

  instr_decoder u_dec (
    .ir     (ir),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .imm    (dec_imm),
    .legal  (dec_legal),
    .wr_reg (dec_wr)
  );

  // A single-cycle op (or a multi-cycle op whose done arrives) ends EXEC;
  // done takes priority over the timeout on the same cycle.
  assign exec_go_wb   = !exec_multi || exec_done;
  assign exec_timeout = (exec_cnt == CNT_W'(EXEC_TIMEOUT - 1));

  // The request is gated by rst so it drops the moment reset asserts.
  assign instr_req  = (state == FETCH) && !rst;
  assign instr_addr = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (instr_ack) state_nxt = DECODE;
      DECODE: begin
        if (!dec_legal)                state_nxt = FETCH;
        else if (dec_opcode == OP_HALT) state_nxt = HALT_ST;
        else                           state_nxt = EXEC;
      end
      EXEC: begin
        if (exec_go_wb)        state_nxt = WB;
        else if (exec_timeout) state_nxt = FETCH;
      end
      WB:      state_nxt = FETCH;
      HALT_ST: state_nxt = HALT_ST;
      default: state_nxt = FETCH;
    endcase
  end

  // Instruction register and program counter; JMP retargets the PC in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_WIDTH'(RESET_PC);
      ir <= '0;
    end else if (state == FETCH && instr_ack) begin
      ir <= instr_data;
      pc <= pc + 1'b1;
    end else if (state == WB && dec_opcode == OP_JMP) begin
      pc <= PC_WIDTH'(dec_imm);
    end
  end

  // EXEC wait counter, cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                exec_cnt <= '0;
    else if (state == EXEC) exec_cnt <= exec_cnt + 1'b1;
    else                    exec_cnt <= '0;
  end

  // Registered bus fields, write enable and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_bus_if.OPCODE <= OP_NOP;
      ctrl_bus_if.RD     <= '0;
      ctrl_bus_if.RS1    <= '0;
      ctrl_bus_if.RS2    <= '0;
      ctrl_bus_if.IMM    <= '0;
      ctrl_bus_if.REG_WE <= 1'b0;
      halted             <= 1'b0;
      fault              <= 1'b0;
    end else begin
      ctrl_bus_if.REG_WE <= 1'b0;
      fault              <= 1'b0;
      case (state)
        DECODE: begin
          ctrl_bus_if.RD  <= dec_rd;
          ctrl_bus_if.RS1 <= dec_rs1;
          ctrl_bus_if.RS2 <= dec_rs2;
          ctrl_bus_if.IMM <= dec_imm;
          if (!dec_legal) begin
            ctrl_bus_if.OPCODE <= OP_NOP;
            fault              <= 1'b1;
          end else if (dec_opcode == OP_HALT) begin
            ctrl_bus_if.OPCODE <= OP_NOP;
            halted             <= 1'b1;
          end else begin
            ctrl_bus_if.OPCODE <= dec_opcode;
          end
        end
        EXEC: begin
          if (exec_go_wb)        ctrl_bus_if.REG_WE <= dec_wr;
          else if (exec_timeout) fault              <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instruction streams checked against a per-instruction reference model.
module tb_control_unit;

  localparam int PC_W    = 8;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int TIMEOUT = 15;

  localparam logic [4:0] T_NOP  = 5'd0;
  localparam logic [4:0] T_HALT = 5'd1;
  localparam logic [4:0] T_JMP  = 5'd2;
  localparam logic [4:0] T_AND  = 5'd3;
  localparam logic [4:0] T_OR   = 5'd4;
  localparam logic [4:0] T_XOR  = 5'd5;
  localparam logic [4:0] T_NOT  = 5'd6;
  localparam logic [4:0] T_ADD  = 5'd7;
  localparam logic [4:0] T_SUB  = 5'd8;

  logic [4:0] legal_ops [9] = '{T_NOP, T_HALT, T_JMP, T_AND, T_OR, T_XOR, T_NOT, T_ADD, T_SUB};
  logic [4:0] data_ops  [7] = '{T_NOP, T_AND, T_OR, T_XOR, T_NOT, T_ADD, T_SUB};

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] instr_addr;
  logic            instr_req;
  logic            instr_ack;
  logic [18:0]     instr_data;
  logic            exec_multi;
  logic            exec_done;
  logic            halted;
  logic            fault;

  int tests = 0;
  int fails = 0;
  int m_pc  = 0;

  control_bus_if bus ();

  control_unit #(
    .PC_WIDTH     (PC_W),
    .RESET_PC     (0),
    .EXEC_TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_bus_if (bus),
    .instr_addr  (instr_addr),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .instr_data  (instr_data),
    .exec_multi  (exec_multi),
    .exec_done   (exec_done),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (instr_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req"}, 32'(instr_req), 1);
  endtask

  function automatic logic [18:0] make_word(input logic [4:0] opc);
    logic [13:0] rest;
    rest = 14'($urandom);
    return {opc, rest};
  endfunction

  // One instruction end to end. done_at is the EXEC cycle (1-based) that
  // carries exec_done; values outside 1..TIMEOUT mean done never arrives.
  task automatic do_instr(input logic [18:0] w, input int wait_cyc, input bit multi,
                          input int done_at, input string tag);
    logic [4:0] opc;
    logic [2:0] rd, rs1, rs2;
    logic [4:0] imm;
    bit         legal, wr, tmo;
    int         n_exec;
    opc = w[18:14]; rd = w[13:11]; rs1 = w[10:8]; rs2 = w[7:5]; imm = w[4:0];
    legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == opc) legal = 1'b1;
    wr     = legal && !(opc inside {T_NOP, T_JMP, T_HALT});
    tmo    = multi && (done_at < 1 || done_at > TIMEOUT);
    n_exec = !multi ? 1 : (tmo ? TIMEOUT : done_at);

    wait_req(tag);
    check({tag, " addr"}, 32'(instr_addr), 32'(m_pc));
    for (int k = 0; k < wait_cyc; k++) begin
      @(negedge clk);
      check({tag, " wait req"}, 32'(instr_req), 1);
      check({tag, " wait addr"}, 32'(instr_addr), 32'(m_pc));
    end
    instr_ack  = 1'b1;
    instr_data = w;
    @(negedge clk);
    instr_data = 19'($urandom);
    instr_ack  = 1'($urandom_range(0, 1));
    m_pc = (m_pc + 1) % PC_MOD;
    check({tag, " decode req"}, 32'(instr_req), 0);
    check({tag, " decode we"}, 32'(bus.REG_WE), 0);
    exec_multi = multi;
    exec_done  = 1'b0;
    @(negedge clk);
    instr_ack = 1'($urandom_range(0, 1));

    if (!legal) begin
      instr_ack = 1'b0;
      exec_multi = 1'b0;
      check({tag, " illegal fault"}, 32'(fault), 1);
      check({tag, " illegal opcode"}, 32'(bus.OPCODE), 32'(T_NOP));
      check({tag, " illegal we"}, 32'(bus.REG_WE), 0);
      check({tag, " illegal next addr"}, 32'(instr_addr), 32'(m_pc));
      return;
    end
    if (opc == T_HALT) begin
      instr_ack = 1'b0;
      exec_multi = 1'b0;
      check({tag, " halted"}, 32'(halted), 1);
      check({tag, " halt req"}, 32'(instr_req), 0);
      check({tag, " halt opcode"}, 32'(bus.OPCODE), 32'(T_NOP));
      check({tag, " halt fault"}, 32'(fault), 0);
      return;
    end

    for (int c = 1; c <= n_exec; c++) begin
      check({tag, " exec opcode"}, 32'(bus.OPCODE), 32'(opc));
      check({tag, " exec rd"}, 32'(bus.RD), 32'(rd));
      check({tag, " exec rs1"}, 32'(bus.RS1), 32'(rs1));
      check({tag, " exec rs2"}, 32'(bus.RS2), 32'(rs2));
      check({tag, " exec imm"}, 32'(bus.IMM), 32'(imm));
      check({tag, " exec we"}, 32'(bus.REG_WE), 0);
      check({tag, " exec fault"}, 32'(fault), 0);
      exec_done = multi && (c == done_at);
      if (c > 1) instr_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    exec_done  = 1'b0;
    exec_multi = 1'b0;

    if (tmo) begin
      instr_ack = 1'b0;
      check({tag, " timeout fault"}, 32'(fault), 1);
      check({tag, " timeout we"}, 32'(bus.REG_WE), 0);
      check({tag, " timeout req"}, 32'(instr_req), 1);
      return;
    end
    check({tag, " wb we"}, 32'(bus.REG_WE), 32'(wr));
    check({tag, " wb fault"}, 32'(fault), 0);
    check({tag, " wb req"}, 32'(instr_req), 0);
    if (opc == T_JMP) m_pc = int'(imm);
    instr_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    instr_ack = 1'b0;
    check({tag, " post-wb we"}, 32'(bus.REG_WE), 0);
  endtask

  initial begin
    logic [18:0] w;
    int          r;
    rst        = 1'b1;
    instr_ack  = 1'b1;
    instr_data = 19'h7ffff;
    exec_multi = 1'b0;
    exec_done  = 1'b0;
    repeat (3) @(negedge clk);

    check("reset req", 32'(instr_req), 0);
    check("reset addr", 32'(instr_addr), 0);
    check("reset halted", 32'(halted), 0);
    check("reset fault", 32'(fault), 0);
    check("reset opcode", 32'(bus.OPCODE), 32'(T_NOP));
    check("reset we", 32'(bus.REG_WE), 0);
    check("reset fields", 32'({bus.RD, bus.RS1, bus.RS2, bus.IMM}), 0);
    instr_ack = 1'b0;
    rst = 1'b0;
    m_pc = 0;

    do_instr(19'b00011_001_010_011_00000, 0, 1'b0, 0, "t1_and");
    do_instr(make_word(T_ADD), 5, 1'b0, 0, "t2_wait");
    do_instr(make_word(T_SUB), 0, 1'b1, 3, "t3_multi");
    do_instr(make_word(T_XOR), 1, 1'b1, 0, "t4_timeout");
    do_instr(make_word(T_OR), 0, 1'b1, TIMEOUT, "t4_done_at_limit");
    do_instr({5'b11111, 14'($urandom)}, 0, 1'b0, 0, "t5_illegal");
    do_instr({T_JMP, 9'($urandom), 5'd7}, 0, 1'b0, 0, "t5_jmp");
    check("t5 jmp target", 32'(instr_addr), 7);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      w = {5'(9 + $urandom_range(0, 22)), 14'($urandom)};
      else if (r == 1) w = make_word(T_JMP);
      else             w = make_word(data_ops[$urandom_range(0, 6)]);
      do_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(1, TIMEOUT + 2), "rand");
    end

    // Reset in the middle of a fetch handshake: ack must be discarded.
    wait_req("rst_fetch");
    instr_ack  = 1'b1;
    instr_data = 19'b00011_001_010_011_00000;
    rst        = 1'b1;
    #1;
    check("rst_fetch req drop", 32'(instr_req), 0);
    @(negedge clk);
    instr_ack = 1'b0;
    rst       = 1'b0;
    #1;
    m_pc = 0;
    check("rst_fetch req back", 32'(instr_req), 1);
    check("rst_fetch addr", 32'(instr_addr), 0);
    check("rst_fetch opcode", 32'(bus.OPCODE), 32'(T_NOP));

    // Walk the PC to its top value, then confirm it wraps.
    for (int g = 0; g < 300 && m_pc != PC_MOD - 1; g++)
      do_instr(make_word(data_ops[$urandom_range(0, 6)]), 0, 1'b0, 0, "walk");
    check("walk addr top", 32'(instr_addr), 32'(PC_MOD - 1));
    do_instr(make_word(T_ADD), 0, 1'b0, 0, "wrap");
    check("wrap addr", 32'(instr_addr), 0);

    // Reset while stuck in a multi-cycle EXEC.
    wait_req("rst_exec");
    instr_ack  = 1'b1;
    instr_data = {T_ADD, 3'd5, 3'd6, 3'd7, 5'd21};
    @(negedge clk);
    instr_ack  = 1'b0;
    exec_multi = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_exec pre opcode", 32'(bus.OPCODE), 32'(T_ADD));
    rst = 1'b1;
    #1;
    check("rst_exec req", 32'(instr_req), 0);
    check("rst_exec opcode", 32'(bus.OPCODE), 32'(T_NOP));
    check("rst_exec fields", 32'({bus.RD, bus.RS1, bus.RS2, bus.IMM}), 0);
    check("rst_exec we", 32'(bus.REG_WE), 0);
    check("rst_exec addr", 32'(instr_addr), 0);
    check("rst_exec fault", 32'(fault), 0);
    @(negedge clk);
    exec_multi = 1'b0;
    rst = 1'b0;
    m_pc = 0;

    do_instr(make_word(T_NOT), 0, 1'b0, 0, "post_rst");
    do_instr(make_word(T_HALT), 0, 1'b0, 0, "halt");
    for (int h = 0; h < 8; h++) begin
      instr_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt sticky", 32'(halted), 1);
      check("halt no req", 32'(instr_req), 0);
      check("halt no we", 32'(bus.REG_WE), 0);
    end
    instr_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
